// File: rtl/ccip_tx_almfull_buffer_if.sv
// rtl/ccip_tx_almfull_buffer_if.sv - CCI-P Tx channel bundle (c0 read, c1 write, c2 MMIO response)
interface ccip_tx_almfull_buffer_if #(
  parameter int C0H_W = 64,
  parameter int C1H_W = 80,
  parameter int C1D_W = 64,
  parameter int C2H_W = 16,
  parameter int C2D_W = 64
);
  logic             c0_valid;
  logic [C0H_W-1:0] c0_hdr;
  logic             c1_valid;
  logic [C1H_W-1:0] c1_hdr;
  logic [C1D_W-1:0] c1_data;
  logic             c2_valid;
  logic [C2H_W-1:0] c2_hdr;
  logic [C2D_W-1:0] c2_data;

  modport master (
    output c0_valid, c0_hdr,
    output c1_valid, c1_hdr, c1_data,
    output c2_valid, c2_hdr, c2_data
  );

  modport slave (
    input c0_valid, c0_hdr,
    input c1_valid, c1_hdr, c1_data,
    input c2_valid, c2_hdr, c2_data
  );
endinterface

// File: rtl/ccip_tx_almfull_buffer.sv
// rtl/ccip_tx_almfull_buffer.sv - per-channel Tx request buffer with occupancy-based almost-full
// Channels c0/c1 are FIFO-buffered behind FIU almost-full; c2 is a one-stage register.
module ccip_tx_almfull_chan #(
  parameter int DEPTH = 16,
  parameter int SLACK = 8,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_payload_i,
  input  logic         fiu_almfull_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_payload_o,
  output logic         almfull_o,
  output logic         overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] SLACK_C = CW'(SLACK);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_payload_q;
  logic          almfull_q, almfull_d;
  logic          overflow_q, overflow_d;

  logic          empty;
  logic          push;
  logic          pop;
  logic          fifo_rd;
  logic          fifo_wr;
  logic [W-1:0]  head;

  always_comb begin
    empty   = (cnt_q == '0);
    // An empty FIFO lets the incoming request go straight to the output register.
    pop     = !fiu_almfull_i && (!empty || in_valid_i);
    push    = in_valid_i && ((cnt_q != DEPTH_C) || pop);
    fifo_rd = pop && !empty;
    fifo_wr = push && !(pop && empty);
    head    = empty ? in_payload_i : mem_q[rd_ptr_q];

    wr_ptr_d    = wr_ptr_q + AW'(fifo_wr);
    rd_ptr_d    = rd_ptr_q + AW'(fifo_rd);
    cnt_d       = cnt_q + CW'(push) - CW'(pop);
    out_valid_d = pop;
    almfull_d   = ((DEPTH_C - cnt_d) <= SLACK_C);
    overflow_d  = overflow_q || (in_valid_i && !push);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      almfull_q   <= 1'b1;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      almfull_q   <= almfull_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage and output payload carry no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem_q[wr_ptr_q] <= in_payload_i;
    end
    if (pop) begin
      out_payload_q <= head;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_payload_o = out_payload_q;
  assign almfull_o     = almfull_q;
  assign overflow_o    = overflow_q;
endmodule

module ccip_tx_almfull_buffer #(
  parameter int DEPTH = 16,
  parameter int SLACK = 8,
  parameter int C0H_W = 64,
  parameter int C1H_W = 80,
  parameter int C1D_W = 64,
  parameter int C2H_W = 16,
  parameter int C2D_W = 64
) (
  input  logic                           clk,
  input  logic                           reset_n,
  ccip_tx_almfull_buffer_if.slave        tx_in,
  ccip_tx_almfull_buffer_if.master       tx_out,
  input  logic                           c0TxAlmFull_fiu,
  input  logic                           c1TxAlmFull_fiu,
  output logic                           c0TxAlmFull_out,
  output logic                           c1TxAlmFull_out,
  output logic [1:0]                     overflow_err
);
  localparam int C1W = C1H_W + C1D_W;

  logic [C1W-1:0]   c1_out_payload;
  logic             c0_ovf;
  logic             c1_ovf;
  logic             c2_valid_q;
  logic [C2H_W-1:0] c2_hdr_q;
  logic [C2D_W-1:0] c2_data_q;

  ccip_tx_almfull_chan #(
    .DEPTH (DEPTH),
    .SLACK (SLACK),
    .W     (C0H_W)
  ) u_c0 (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid_i    (tx_in.c0_valid),
    .in_payload_i  (tx_in.c0_hdr),
    .fiu_almfull_i (c0TxAlmFull_fiu),
    .out_valid_o   (tx_out.c0_valid),
    .out_payload_o (tx_out.c0_hdr),
    .almfull_o     (c0TxAlmFull_out),
    .overflow_o    (c0_ovf)
  );

  // Fences and interrupts ride the c1 FIFO like any other request.
  ccip_tx_almfull_chan #(
    .DEPTH (DEPTH),
    .SLACK (SLACK),
    .W     (C1W)
  ) u_c1 (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid_i    (tx_in.c1_valid),
    .in_payload_i  ({tx_in.c1_hdr, tx_in.c1_data}),
    .fiu_almfull_i (c1TxAlmFull_fiu),
    .out_valid_o   (tx_out.c1_valid),
    .out_payload_o (c1_out_payload),
    .almfull_o     (c1TxAlmFull_out),
    .overflow_o    (c1_ovf)
  );

  assign tx_out.c1_hdr  = c1_out_payload[C1W-1:C1D_W];
  assign tx_out.c1_data = c1_out_payload[C1D_W-1:0];
  assign overflow_err   = {c1_ovf, c0_ovf};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c2_valid_q <= 1'b0;
    end else begin
      c2_valid_q <= tx_in.c2_valid;
    end
  end

  always_ff @(posedge clk) begin
    c2_hdr_q  <= tx_in.c2_hdr;
    c2_data_q <= tx_in.c2_data;
  end

  assign tx_out.c2_valid = c2_valid_q;
  assign tx_out.c2_hdr   = c2_hdr_q;
  assign tx_out.c2_data  = c2_data_q;
endmodule
